dvp_pixel_assembler: RTL

// - Next-generation DVP RX back end. Sits between the pixel-info FIFO and the gray-scale/ISP stage.
// - Packs 1..MAX_BPP DVP bytes into one pixel and tracks frame and line boundaries from the sync flags.
// - Provides frame-aligned start/stop, a drop-on-stall mode and error pulses for alignment, line length and overflow.

---
 rtl/dvp_pkg.sv | 24 ++
 rtl/dvp_pxl_out_reg.sv | 61 ++++++
 rtl/dvp_pixel_assembler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - Shared state encoding, field indices and bpp helpers for the DVP receive path
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE_ST     = 2'd0,
    WAIT_SOF_ST = 2'd1,
    ACTIVE_ST   = 2'd2
  } dvp_state_e;

  localparam int DVP_DATA_W_DFLT = 8;
  localparam int PXL_HSYNC_IDX   = DVP_DATA_W_DFLT;
  localparam int PXL_VSYNC_IDX   = DVP_DATA_W_DFLT + 1;

  localparam logic [1:0] BPP_GS     = 2'd1;
  localparam logic [1:0] BPP_RGB565 = 2'd2;
  localparam logic [1:0] BPP_RGB888 = 2'd3;

  // Out-of-range byte counts fall back to single-byte gray-scale.
  function automatic logic [1:0] bpp_sanitize(input logic [1:0] bpp, input int max_bpp);
    if (bpp == 2'd0 || int'(bpp) > max_bpp) return BPP_GS;
    return bpp;
  endfunction

endpackage

// File: rtl/dvp_pxl_out_reg.sv
// rtl/dvp_pxl_out_reg.sv - Single-entry valid/ready pixel output register with a drop input
module dvp_pxl_out_reg #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld_i,
  input  logic              in_drop_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sof_i,
  input  logic              in_sol_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sof_o,
  output logic              out_sol_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i
);

  logic              load;
  logic              vld_d, vld_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              sof_d, sof_q;
  logic              sol_d, sol_q;

  // A dropped pixel never touches the held entry, so it stays stable under stall.
  always_comb begin
    load   = in_vld_i & ~in_drop_i;
    vld_d  = vld_q;
    data_d = data_q;
    sof_d  = sof_q;
    sol_d  = sol_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = in_data_i;
      sof_d  = in_sof_i;
      sol_d  = in_sol_i;
    end else if (out_rdy_i) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sof_q  <= 1'b0;
      sol_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      sof_q  <= sof_d;
      sol_q  <= sol_d;
    end
  end

  assign out_vld_o  = vld_q;
  assign out_data_o = data_q;
  assign out_sof_o  = sof_q;
  assign out_sol_o  = sol_q;

endmodule

// File: rtl/dvp_pixel_assembler.sv
// rtl/dvp_pixel_assembler.sv - DVP RX back end: packs bytes into pixels, tracks frame/line sync
module dvp_pixel_assembler
  import dvp_pkg::*;
#(
  parameter int DVP_DATA_W = 8,
  parameter int MAX_BPP    = 3,
  parameter int LINE_CNT_W = 12,
  parameter int FRM_CNT_W  = 16,
  parameter int PXL_INFO_W = DVP_DATA_W + 2,
  parameter int OUT_PXL_W  = MAX_BPP * DVP_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PXL_INFO_W-1:0] pxl_info_i,
  input  logic                  pxl_info_vld_i,
  output logic                  pxl_info_rdy_o,
  input  logic                  cfg_start_i,
  input  logic                  cfg_stop_i,
  input  logic [1:0]            cfg_bpp_i,
  input  logic [LINE_CNT_W-1:0] cfg_line_pxl_i,
  input  logic                  cfg_drop_mode_i,
  output logic [OUT_PXL_W-1:0]  pxl_o,
  output logic                  pxl_sof_o,
  output logic                  pxl_sol_o,
  output logic                  pxl_vld_o,
  input  logic                  pxl_rdy_i,
  output logic                  busy_o,
  output logic [FRM_CNT_W-1:0]  frm_cnt_o,
  output logic                  err_align_o,
  output logic                  err_line_o,
  output logic                  err_ovf_o
);

  localparam int VS_IDX = DVP_DATA_W + 1;
  localparam int HS_IDX = DVP_DATA_W;

  dvp_state_e            state_d, state_q;
  logic                  stop_pend_d, stop_pend_q;
  logic [1:0]            byte_idx_d, byte_idx_q;
  logic [1:0]            bpp_d, bpp_q;
  logic [LINE_CNT_W-1:0] line_pxl_d, line_pxl_q;
  logic [LINE_CNT_W-1:0] line_cnt_d, line_cnt_q;
  logic [FRM_CNT_W-1:0]  frm_cnt_d, frm_cnt_q;
  logic [OUT_PXL_W-1:0]  pix_d, pix_q;
  logic                  sof0_d, sof0_q;
  logic                  sol0_d, sol0_q;
  logic                  err_align_d, err_align_q;
  logic                  err_line_d, err_line_q;
  logic                  err_ovf_d, err_ovf_q;

  logic                  beat_vs, beat_hs, sync, pop, rdy;
  logic [DVP_DATA_W-1:0] beat_data;
  logic                  sof_beat, take, chk, last, complete, ovf;
  logic [1:0]            eff_bpp, idx;
  logic [OUT_PXL_W-1:0]  pix_new;
  logic                  sof_new, sol_new;
  logic                  out_vld;

  always_comb begin
    beat_vs   = pxl_info_i[VS_IDX];
    beat_hs   = pxl_info_i[HS_IDX];
    beat_data = pxl_info_i[DVP_DATA_W-1:0];
    sync      = beat_vs | beat_hs;

    // Ready depends only on state and the output register, never on the beat contents.
    if (state_q == ACTIVE_ST)
      rdy = cfg_drop_mode_i | (byte_idx_q != bpp_q - 2'd1) | ~out_vld | pxl_rdy_i;
    else
      rdy = 1'b1;
    pop = pxl_info_vld_i & rdy;

    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    byte_idx_d  = byte_idx_q;
    bpp_d       = bpp_q;
    line_pxl_d  = line_pxl_q;
    line_cnt_d  = line_cnt_q;
    frm_cnt_d   = frm_cnt_q;
    pix_d       = pix_q;
    sof0_d      = sof0_q;
    sol0_d      = sol0_q;
    err_align_d = 1'b0;
    err_line_d  = 1'b0;
    err_ovf_d   = 1'b0;
    sof_beat    = 1'b0;
    take        = 1'b0;
    chk         = 1'b0;

    case (state_q)
      IDLE_ST: begin
        if (cfg_start_i && !cfg_stop_i) state_d = WAIT_SOF_ST;
      end
      WAIT_SOF_ST: begin
        if (cfg_stop_i) begin
          state_d     = IDLE_ST;
          stop_pend_d = 1'b0;
        end else if (pop && beat_vs) begin
          state_d  = ACTIVE_ST;
          sof_beat = 1'b1;
          take     = 1'b1;
        end
      end
      ACTIVE_ST: begin
        if (cfg_stop_i) stop_pend_d = 1'b1;
        if (pop) begin
          if (sync) begin
            chk         = 1'b1;
            err_align_d = (byte_idx_q != 2'd0);
          end
          if (beat_vs) frm_cnt_d = frm_cnt_q + FRM_CNT_W'(1);
          if (beat_vs && stop_pend_q) begin
            state_d     = IDLE_ST;
            stop_pend_d = 1'b0;
            byte_idx_d  = 2'd0;
          end else begin
            take     = 1'b1;
            sof_beat = beat_vs;
          end
        end
      end
      default: state_d = IDLE_ST;
    endcase

    // Frame geometry is captured on the SOF beat and applies to that beat already.
    eff_bpp = sof_beat ? bpp_sanitize(cfg_bpp_i, MAX_BPP) : bpp_q;
    if (sof_beat) begin
      bpp_d      = eff_bpp;
      line_pxl_d = cfg_line_pxl_i;
    end

    idx     = sync ? 2'd0 : byte_idx_q;
    last    = (idx == eff_bpp - 2'd1);
    pix_new = (idx == 2'd0) ? '0 : pix_q;
    for (int i = 0; i < MAX_BPP; i++) begin
      if (int'(idx) == i) pix_new[i*DVP_DATA_W +: DVP_DATA_W] = beat_data;
    end
    sof_new = (idx == 2'd0) ? beat_vs : sof0_q;
    sol_new = (idx == 2'd0) ? sync    : sol0_q;

    complete = take & last;
    if (take) begin
      pix_d      = pix_new;
      sof0_d     = sof_new;
      sol0_d     = sol_new;
      byte_idx_d = last ? 2'd0 : idx + 2'd1;
    end

    ovf       = complete & out_vld & ~pxl_rdy_i;
    err_ovf_d = ovf;

    if (chk) begin
      err_line_d = (line_pxl_q != '0) && (line_cnt_q != line_pxl_q);
      line_cnt_d = {{(LINE_CNT_W-1){1'b0}}, complete};
    end else if (complete) begin
      line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_ST;
      stop_pend_q <= 1'b0;
      byte_idx_q  <= 2'd0;
      bpp_q       <= BPP_GS;
      line_pxl_q  <= '0;
      line_cnt_q  <= '0;
      frm_cnt_q   <= '0;
      pix_q       <= '0;
      sof0_q      <= 1'b0;
      sol0_q      <= 1'b0;
      err_align_q <= 1'b0;
      err_line_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      byte_idx_q  <= byte_idx_d;
      bpp_q       <= bpp_d;
      line_pxl_q  <= line_pxl_d;
      line_cnt_q  <= line_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      pix_q       <= pix_d;
      sof0_q      <= sof0_d;
      sol0_q      <= sol0_d;
      err_align_q <= err_align_d;
      err_line_q  <= err_line_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  dvp_pxl_out_reg #(
    .DATA_W (OUT_PXL_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld_i   (complete),
    .in_drop_i  (ovf),
    .in_data_i  (pix_new),
    .in_sof_i   (sof_new),
    .in_sol_i   (sol_new),
    .out_data_o (pxl_o),
    .out_sof_o  (pxl_sof_o),
    .out_sol_o  (pxl_sol_o),
    .out_vld_o  (out_vld),
    .out_rdy_i  (pxl_rdy_i)
  );

  assign pxl_vld_o      = out_vld;
  assign pxl_info_rdy_o = rdy;
  assign busy_o         = (state_q != IDLE_ST);
  assign frm_cnt_o      = frm_cnt_q;
  assign err_align_o    = err_align_q;
  assign err_line_o     = err_line_q;
  assign err_ovf_o      = err_ovf_q;

endmodule
